// File: rtl/prm_edge_chk_sched.sv
// Edge sequencer for the PRM obstacle-check bank: fetches edge codes, broadcasts them to the
// checkers and streams per-edge hit results. Optional early exit on first blocked edge: PRM_SCHED_EARLY_EXIT_EN.
module prm_edge_chk_sched #(
  parameter int NUM_CHK = 8,
  parameter int EDGE_AW = 10,
  parameter int CODE_W  = 15
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [EDGE_AW-1:0] i_edge_base,
  input  logic [EDGE_AW:0]   i_edge_cnt,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_early_stop,
  output logic [EDGE_AW:0]   o_blocked_cnt,
  output logic               o_mem_rd_en,
  output logic [EDGE_AW-1:0] o_mem_addr,
  input  logic [CODE_W-1:0]  i_mem_rdata,
  output logic [CODE_W-1:0]  o_chk_code,
  input  logic [NUM_CHK-1:0] i_chk_mask,
  output logic               o_res_valid,
  input  logic               i_res_ready,
  output logic [EDGE_AW:0]   o_res_idx,
  output logic [NUM_CHK-1:0] o_res_hits,
  output logic               o_res_blocked
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_CHECK = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam logic [EDGE_AW:0] IDX_ONE = {{EDGE_AW{1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_next;
  logic [EDGE_AW-1:0]   r_base;
  logic [EDGE_AW:0]     r_cnt;
  logic [EDGE_AW:0]     r_idx;
  logic [EDGE_AW:0]     r_blocked_cnt;
  logic [CODE_W-1:0]    r_chk_code;
  logic [EDGE_AW:0]     r_res_idx;
  logic [NUM_CHK-1:0]   r_res_hits;
  logic                 r_res_blocked;
  logic                 r_early;
  logic                 w_start_ok;
  logic                 w_hs;
  logic                 w_last;
  logic                 w_early_exit;
  logic [EDGE_AW:0]     w_idx_nxt;

  assign w_start_ok = (r_state == S_IDLE) && i_start;
  // Abort beats a simultaneous handshake: the result is treated as undelivered.
  assign w_hs       = (r_state == S_EMIT) && i_res_ready && !i_abort;
  assign w_idx_nxt  = r_idx + IDX_ONE;
  assign w_last     = (w_idx_nxt == r_cnt);

`ifdef PRM_SCHED_EARLY_EXIT_EN
  assign w_early_exit = r_res_blocked;
`else
  assign w_early_exit = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_abort && (r_state != S_IDLE)) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) w_next = (i_edge_cnt == '0) ? S_DONE : S_FETCH;
        S_FETCH: w_next = S_LOAD;
        S_LOAD:  w_next = S_CHECK;
        S_CHECK: w_next = S_EMIT;
        S_EMIT:  if (w_hs) w_next = (w_last || w_early_exit) ? S_DONE : S_FETCH;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_base        <= '0;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_blocked_cnt <= '0;
      r_chk_code    <= '0;
      r_res_idx     <= '0;
      r_res_hits    <= '0;
      r_res_blocked <= 1'b0;
      r_early       <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_base        <= i_edge_base;
        r_cnt         <= i_edge_cnt;
        r_idx         <= '0;
        r_blocked_cnt <= '0;
        r_early       <= 1'b0;
      end
      if ((r_state == S_LOAD) && !i_abort) r_chk_code <= i_mem_rdata;
      // chk_mask has had a full cycle to settle on the code loaded in LOAD.
      if ((r_state == S_CHECK) && !i_abort) begin
        r_res_hits    <= i_chk_mask;
        r_res_blocked <= |i_chk_mask;
        r_res_idx     <= r_idx;
        if (|i_chk_mask) r_blocked_cnt <= r_blocked_cnt + IDX_ONE;
      end
      if (w_hs) begin
        r_idx   <= w_idx_nxt;
        r_early <= w_early_exit;
      end
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_early_stop  = (r_state == S_DONE) && r_early;
  assign o_mem_rd_en   = (r_state == S_FETCH);
  assign o_mem_addr    = r_base + r_idx[EDGE_AW-1:0];
  assign o_res_valid   = (r_state == S_EMIT);
  assign o_blocked_cnt = r_blocked_cnt;
  assign o_chk_code    = r_chk_code;
  assign o_res_idx     = r_res_idx;
  assign o_res_hits    = r_res_hits;
  assign o_res_blocked = r_res_blocked;

endmodule

// File: doc/prm_edge_chk_sched.md
# prm_edge_chk_sched

Sequencer for the PRM obstacle-check bank. It walks a list of roadmap edges held in an external edge-code memory and presents each 15-bit quantised edge code (inputs A..O) to a bank of NUM_CHK combinational obstacle checkers (prm_oblgc_chk* instances). For every edge it samples the checkers' edge_mask outputs and streams a per-edge blocked/hit result to the roadmap builder over a valid/ready interface. Sits between the roadmap edge store and the path planner.

## Interface
- NUM_CHK, 8, number of obstacle checker instances in the bank
- EDGE_AW, 10, edge-memory address width
- CODE_W, 15, edge code width; bit 0 = A … bit 14 = O
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin run; accepted only in IDLE
- abort  in  1  synchronous abort of a run
- edge_base  in  EDGE_AW  first edge address; sampled on accepted start
- edge_cnt  in  EDGE_AW+1  number of edges; sampled on accepted start
- busy  out  1  high from the cycle after an accepted start until DONE exits
- done  out  1  one-cycle pulse at end of run; not pulsed on abort
- early_stop  out  1  run ended by early exit; valid with done
- blocked_cnt  out  EDGE_AW+1  edges with any hit in the current or last run
- mem_rd_en  out  1  edge-memory read strobe
- mem_addr  out  EDGE_AW  read address
- mem_rdata  in  CODE_W  read data, fixed 1-cycle latency after mem_rd_en
- chk_code  out  CODE_W  registered code broadcast to all checkers
- chk_mask  in  NUM_CHK  edge_mask of each checker; combinational from chk_code
- res_valid  out  1  result available
- res_ready  in  1  consumer accept
- res_idx  out  EDGE_AW+1  edge ordinal within the run, 0-based
- res_hits  out  NUM_CHK  captured chk_mask
- res_blocked  out  1  OR-reduction of res_hits

## Operation
- The FSM has six states: IDLE, FETCH, LOAD, CHECK, EMIT, DONE.
- **IDLE:** on start with edge_cnt≠0, latch base and count, clear idx and blocked_cnt, go to FETCH. On start with edge_cnt=0, go to DONE directly.
- **FETCH:** mem_rd_en=1, mem_addr=edge_base+idx (mod 2^EDGE_AW, wraps). Go to LOAD.
- **LOAD:** chk_code←mem_rdata. Go to CHECK.
- **CHECK:** res_hits←chk_mask, res_blocked←|chk_mask, res_idx←idx; blocked_cnt increments if blocked. Go to EMIT.
- **EMIT:** res_valid=1. Result fields are held stable until res_valid&res_ready. On handshake: idx++. If idx+1==count, or the early exit fires (see Configuration), go to DONE; otherwise go to FETCH.
- **DONE:** done=1 for one cycle, then go to IDLE.
- **abort:** from any non-IDLE state, abort goes to IDLE next cycle. res_valid drops, done is not pulsed, blocked_cnt holds its value.
- **Simultaneous abort and handshake:** abort wins. The result counts as not delivered.
- start during busy is ignored.
- chk_code holds its value between edges and in IDLE.
- mem_rd_en is high only in FETCH.

## Timing
- **Reset values:** state=IDLE; busy, done, early_stop, mem_rd_en, res_valid = 0; mem_addr, chk_code, res_idx, res_hits, blocked_cnt = 0; res_blocked = 0.
- **Per-edge sequence:**
  - start accepted in cycle 0
  - FETCH in cycle 1
  - LOAD in cycle 2
  - CHECK in cycle 3
  - res_valid in cycle 4
- Throughput is 4 cycles/edge when res_ready is held high. res_ready low stalls in EMIT indefinitely.
- done is asserted the cycle after the final handshake. With edge_cnt=0, done is asserted in cycle 1.
- The checker path is single-cycle: chk_mask must settle within one clock of chk_code changing.

## Configuration
- PRM_SCHED_EARLY_EXIT_EN defined: after the handshake of a result with res_blocked=1, go to DONE, set early_stop=1 with done, and skip the remaining edges.
- Not defined: all edge_cnt edges are always processed, and early_stop is tied to 0.

## Test plan
- **Basic run:** edge_base=0, edge_cnt=3, memory codes 0x0001/0x7FFF/0x1234, checker model flags only 0x1234 on checker 2, res_ready=1 → three results: idx 0,1,2; res_hits 0x00, 0x00, 0x04. blocked_cnt=1. done is asserted in cycle 13.
- **Backpressure:** same run with res_ready low for 5 cycles on idx 1 → res_idx/res_hits stable while stalled, no extra mem_rd_en, done is delayed by 5 cycles.
- **Address wrap and zero count:** edge_base=0x3FF, edge_cnt=2 → mem_addr 0x3FF then 0x000. edge_cnt=0 → done in cycle 1 with no res_valid.
- **Abort:** abort asserted in LOAD of edge 1 → IDLE next cycle, no done, busy=0, blocked_cnt unchanged. A following start runs normally.
- **Early exit:** with PRM_SCHED_EARLY_EXIT_EN, edge_cnt=4, edge 1 blocked → two results, then done with early_stop=1. Without the macro, four results and early_stop=0.
- **Reset mid-run:** rst asserted during EMIT → all outputs return to their reset values immediately. start is ignored while busy (mid-run start has no effect on idx/base).
